// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the small types used across
// the raster generator.
package vga_pkg;

  localparam int unsigned PIX_DIV  = 2;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic        SYNC_POL = 1'b0;

  typedef logic [5:0] color_t;
  typedef logic [9:0] pos_t;

  // Inclusive unsigned range test; positions are zero-extended, never signed.
  function automatic logic in_range(input pos_t v, input int unsigned lo,
                                    input int unsigned hi);
    return (32'(v) >= lo) && (32'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Enabled 0..MAX-1 wrapping position counter; one instance tracks columns,
// another tracks rows.
module vga_wrap_counter
  import vga_pkg::*;
#(
  parameter int unsigned MAX = 800
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output pos_t count,
  output logic wrap
);

  pos_t count_q, count_d;

  assign wrap  = (count_q == pos_t'(MAX - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel divider, column/row counters, and the registered
// sync/RGB pin stage that trails the counters by exactly one pixel.
module vga_timing
  import vga_pkg::pos_t, vga_pkg::color_t, vga_pkg::in_range;
#(
  parameter int unsigned PIX_DIV  = vga_pkg::PIX_DIV,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter logic        SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic       clk,
  input  logic       reset,
  output logic       on,
  output pos_t       colPos,
  output pos_t       rowPos,
  input  color_t     color,
  output logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] vga_r,
  output logic [1:0] vga_g,
  output logic [1:0] vga_b,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  pos_t             col_pos, row_pos;
  logic             col_wrap, row_wrap;

  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  color_t rgb_q, rgb_d;
  logic   frame_tick_q, frame_tick_d;

  // With PIX_DIV=1 the divider never leaves 0, so pix_en stays high.
  assign pix_en = (div_q == DIV_LAST);
  assign div_d  = pix_en ? '0 : div_q + 1'b1;

  vga_wrap_counter #(.MAX(H_TOTAL)) u_col (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .count (col_pos),
    .wrap  (col_wrap)
  );

  vga_wrap_counter #(.MAX(V_TOTAL)) u_row (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en & col_wrap),
    .count (row_pos),
    .wrap  (row_wrap)
  );

  assign colPos = col_pos;
  assign rowPos = row_pos;
  assign on     = (32'(col_pos) < H_ACTIVE) && (32'(row_pos) < V_ACTIVE);

  // Sync and colour are captured together so they stay aligned at the pins.
  always_comb begin
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    rgb_d        = rgb_q;
    frame_tick_d = 1'b0;
    if (pix_en) begin
      hsync_d      = in_range(col_pos, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_d      = in_range(row_pos, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      rgb_d        = on ? color : '0;
      frame_tick_d = col_wrap & row_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      rgb_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      rgb_q        <= rgb_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign vga_r      = rgb_q[5:4];
  assign vga_g      = rgb_q[3:2];
  assign vga_b      = rgb_q[1:0];
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: full-size timing (PIX_DIV=2) over one line plus resets, and
// a shrunken PIX_DIV=1 raster for table vectors and whole-frame behaviour.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, on_a, pix_en_a, hsync_a, vsync_a, tick_a;
  logic [9:0] col_a, row_a;
  logic [5:0] color_a;
  logic [1:0] r_a, g_a, b_a;

  logic       reset_b, on_b, pix_en_b, hsync_b, vsync_b, tick_b;
  logic [9:0] col_b, row_b;
  logic [5:0] color_b;
  logic [1:0] r_b, g_b, b_b;

  int total = 0;
  int bad   = 0;

  vga_timing dut_a (
    .clk(clk), .reset(reset_a), .on(on_a), .colPos(col_a), .rowPos(row_a),
    .color(color_a), .pix_en(pix_en_a), .hsync(hsync_a), .vsync(vsync_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .frame_tick(tick_a)
  );

  // 16 x 8 raster: hsync cols 10..12, vsync rows 5..6, 128 clks per frame.
  vga_timing #(
    .PIX_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset_b), .on(on_b), .colPos(col_b), .rowPos(row_b),
    .color(color_b), .pix_en(pix_en_b), .hsync(hsync_b), .vsync(vsync_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_tick(tick_b)
  );

  typedef struct {
    int         skip;
    logic [5:0] color;
    int         col;
    int         row;
    logic       hs;
    logic       vs;
    logic       tick;
    logic [5:0] rgb;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    repeat (v.skip) begin
      color_b = v.color;
      @(negedge clk);
    end
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, " col"},   32'(col_a), 0);
    checkOutput({tag, " row"},   32'(row_a), 0);
    checkOutput({tag, " hsync"}, 32'(hsync_a), 1);
    checkOutput({tag, " vsync"}, 32'(vsync_a), 1);
    checkOutput({tag, " rgb"},   32'({r_a, g_a, b_a}), 0);
    checkOutput({tag, " tick"},  32'(tick_a), 0);
  endtask

  initial begin
    //          skip color      col row hs   vs   tick rgb
    vecs[0]  = '{0,  6'o00,      0, 0, 1'b1, 1'b1, 1'b0, 6'b000000};
    vecs[1]  = '{1,  6'b110110,  2, 0, 1'b1, 1'b1, 1'b0, 6'b110110};
    vecs[2]  = '{4,  6'b001101,  7, 0, 1'b1, 1'b1, 1'b0, 6'b001101};
    vecs[3]  = '{1,  6'b111111,  9, 0, 1'b1, 1'b1, 1'b0, 6'b000000};
    vecs[4]  = '{1,  6'b101010, 11, 0, 1'b0, 1'b1, 1'b0, 6'b000000};
    vecs[5]  = '{1,  6'b010101, 13, 0, 1'b0, 1'b1, 1'b0, 6'b000000};
    vecs[6]  = '{1,  6'b000011, 15, 0, 1'b1, 1'b1, 1'b0, 6'b000000};
    vecs[7]  = '{1,  6'b100001,  1, 1, 1'b1, 1'b1, 1'b0, 6'b100001};
    vecs[8]  = '{1,  6'b011110,  3, 1, 1'b1, 1'b1, 1'b0, 6'b011110};
    vecs[9]  = '{45, 6'b111111,  1, 4, 1'b1, 1'b1, 1'b0, 6'b000000};
    vecs[10] = '{15, 6'b111111,  1, 5, 1'b1, 1'b0, 1'b0, 6'b000000};
    vecs[11] = '{26, 6'b111111, 12, 6, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[12] = '{4,  6'b111111,  1, 7, 1'b1, 1'b1, 1'b0, 6'b000000};
    vecs[13] = '{14, 6'b111111,  0, 0, 1'b1, 1'b1, 1'b1, 6'b000000};
    vecs[14] = '{1,  6'b110011,  2, 0, 1'b1, 1'b1, 1'b0, 6'b110011};

    reset_a = 1'b1;
    reset_b = 1'b1;
    color_a = '0;
    color_b = '0;

    // ---------------- dut_a: reset state and one free-running line ----------
    repeat (3) begin
      @(negedge clk);
      checkResetA("a reset");
    end
    reset_a = 1'b0;
    begin
      int err_pos = 0, err_pe = 0, err_hs = 0, err_vs = 0, err_rgb = 0;
      int err_tick = 0, hs_low = 0;
      for (int n = 0; n < 1600; n++) begin
        int c, p;
        logic       exp_hs;
        logic [5:0] exp_rgb;
        c = n / 2;
        if (n >= 2) begin
          p       = c - 1;
          exp_hs  = !(p >= 656 && p <= 751);
          exp_rgb = (p < 640) ? 6'(p % 64) : 6'd0;
        end else begin
          exp_hs  = 1'b1;
          exp_rgb = 6'd0;
        end
        if (col_a !== 10'(c) || row_a !== 10'd0) err_pos++;
        if (pix_en_a !== 1'(n % 2)) err_pe++;
        if (hsync_a !== exp_hs) err_hs++;
        if (vsync_a !== 1'b1) err_vs++;
        if ({r_a, g_a, b_a} !== exp_rgb) err_rgb++;
        if (tick_a !== 1'b0) err_tick++;
        if (hsync_a === 1'b0) hs_low++;
        // Garbage between strobes must never reach the pins.
        color_a = (n % 2 == 1) ? 6'((n / 2) % 64) : 6'($urandom);
        @(negedge clk);
      end
      checkOutput("a line pos errors", 32'(err_pos), 0);
      checkOutput("a line pix_en errors", 32'(err_pe), 0);
      checkOutput("a line hsync errors", 32'(err_hs), 0);
      checkOutput("a line vsync errors", 32'(err_vs), 0);
      checkOutput("a line rgb errors", 32'(err_rgb), 0);
      checkOutput("a line tick errors", 32'(err_tick), 0);
      checkOutput("a hsync low clks", 32'(hs_low), 192);
      checkOutput("a wrap col", 32'(col_a), 0);
      checkOutput("a wrap row", 32'(row_a), 1);
      checkOutput("a wrap rgb", 32'({r_a, g_a, b_a}), 0);
    end

    // ---------------- dut_a: constant colour, then mid-line reset -----------
    color_a = 6'b110110;
    repeat (600) @(negedge clk);
    checkOutput("a mid col", 32'(col_a), 300);
    checkOutput("a mid row", 32'(row_a), 1);
    checkOutput("a mid r", 32'(r_a), 3);
    checkOutput("a mid g", 32'(g_a), 1);
    checkOutput("a mid b", 32'(b_a), 2);
    reset_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkResetA("a midreset");
    end
    reset_a = 1'b0;
    checkOutput("a rel0 col", 32'(col_a), 0);
    checkOutput("a rel0 pix_en", 32'(pix_en_a), 0);
    @(negedge clk);
    checkOutput("a rel1 col", 32'(col_a), 0);
    checkOutput("a rel1 pix_en", 32'(pix_en_a), 1);
    checkOutput("a rel1 rgb", 32'({r_a, g_a, b_a}), 0);
    @(negedge clk);
    checkOutput("a rel2 col", 32'(col_a), 1);
    checkOutput("a rel2 row", 32'(row_a), 0);
    checkOutput("a rel2 rgb", 32'({r_a, g_a, b_a}), 32'(6'b110110));
    repeat (1278) @(negedge clk);
    checkOutput("a col640 col", 32'(col_a), 640);
    checkOutput("a col640 rgb", 32'({r_a, g_a, b_a}), 32'(6'b110110));
    repeat (2) @(negedge clk);
    checkOutput("a col641 rgb", 32'({r_a, g_a, b_a}), 0);
    repeat (30) @(negedge clk);
    checkOutput("a col656 hsync", 32'(hsync_a), 1);
    repeat (2) @(negedge clk);
    checkOutput("a col657 col", 32'(col_a), 657);
    checkOutput("a col657 hsync", 32'(hsync_a), 0);

    // ---------------- dut_b: table vectors ----------------------------------
    @(negedge clk);
    reset_b = 1'b0;
    for (int i = 0; i < 15; i++) begin
      string tag;
      tag = $sformatf("b vec%0d", i);
      applyStimulus(vecs[i]);
      checkOutput({tag, " col"},   32'(col_b), 32'(vecs[i].col));
      checkOutput({tag, " row"},   32'(row_b), 32'(vecs[i].row));
      checkOutput({tag, " hsync"}, 32'(hsync_b), 32'(vecs[i].hs));
      checkOutput({tag, " vsync"}, 32'(vsync_b), 32'(vecs[i].vs));
      checkOutput({tag, " tick"},  32'(tick_b), 32'(vecs[i].tick));
      checkOutput({tag, " rgb"},   32'({r_b, g_b, b_b}), 32'(vecs[i].rgb));
      color_b = vecs[i].color;
      @(negedge clk);
    end

    // ---------------- dut_b: reset then three whole frames ------------------
    checkOutput("b pre-reset rgb", 32'({r_b, g_b, b_b}), 32'(6'b110011));
    reset_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("b reset rgb", 32'({r_b, g_b, b_b}), 0);
      checkOutput("b reset hsync", 32'(hsync_b), 1);
      checkOutput("b reset tick", 32'(tick_b), 0);
    end
    reset_b = 1'b0;
    color_b = 6'b101101;
    begin
      int err_pos = 0, err_pe = 0, err_tick = 0, ticks = 0;
      int hs_low = 0, vs_low = 0;
      for (int n = 0; n <= 384; n++) begin
        if (col_b !== 10'(n % 16) || row_b !== 10'((n / 16) % 8)) err_pos++;
        if (pix_en_b !== 1'b1) err_pe++;
        if (tick_b !== ((n > 0) && (n % 128 == 0))) err_tick++;
        if (tick_b === 1'b1) ticks++;
        if (hsync_b === 1'b0) hs_low++;
        if (vsync_b === 1'b0) vs_low++;
        @(negedge clk);
      end
      checkOutput("b frame pos errors", 32'(err_pos), 0);
      checkOutput("b frame pix_en errors", 32'(err_pe), 0);
      checkOutput("b frame tick errors", 32'(err_tick), 0);
      checkOutput("b frame tick count", 32'(ticks), 3);
      checkOutput("b frame hsync low clks", 32'(hs_low), 72);
      checkOutput("b frame vsync low clks", 32'(vs_low), 96);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
